// File: rtl/interlaken_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : interlaken_test_sequencer
// Description : Multi-core, multi-round test sequencer for the Interlaken
//               loopback top. It aggregates the status of NUM_CORES cores and
//               drives their shared reset, packet restart and pm tick. It runs
//               NUM_ROUNDS send/receive rounds, with per-state timeouts and
//               failure capture.
//               Optional debug event stream: define INTERLAKEN_SEQ_EVENT_EN.
//               With the macro undefined, event_valid/event_code are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module interlaken_test_sequencer #(
  parameter int NUM_CORES         = 2,
  parameter int NUM_ROUNDS        = 2,
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 1048576
) (
  input  logic                 init_clk,
  input  logic                 clk_reset,
  input  logic [NUM_CORES-1:0] core_gt_locked,
  input  logic [NUM_CORES-1:0] core_rx_aligned,
  input  logic [NUM_CORES-1:0] core_tx_done,
  input  logic [NUM_CORES-1:0] core_tx_busy,
  input  logic [NUM_CORES-1:0] core_tx_fail,
  input  logic [NUM_CORES-1:0] core_rx_done,
  input  logic [NUM_CORES-1:0] core_rx_busy,
  input  logic [NUM_CORES-1:0] core_rx_failed,
  output logic                 sys_reset,
  output logic                 tx_rx_restart,
  output logic                 pm_tick,
  output logic [3:0]           state_out,
  output logic [7:0]           round_idx,
  output logic                 test_pass,
  output logic                 test_fail,
  output logic [2:0]           fail_code,
  output logic [3:0]           fail_state,
  output logic                 event_valid,
  output logic [3:0]           event_code
);

  typedef enum logic [3:0] {
    ST_RESET_HOLD     = 4'd0,
    ST_GT_LOCK_WAIT   = 4'd1,
    ST_RX_ALIGN_WAIT  = 4'd2,
    ST_PACKET_SEND    = 4'd3,
    ST_PACKET_RECEIVE = 4'd4,
    ST_IDLE_WAIT      = 4'd5,
    ST_RESTART        = 4'd6,
    ST_BUSY_WAIT      = 4'd7,
    ST_DONE           = 4'd8,
    ST_FAIL           = 4'd9
  } state_t;

  localparam logic [31:0] HOLD_LAST    = 32'(RESET_HOLD_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  LAST_ROUND   = 8'(NUM_ROUNDS - 1);

  state_t      state;
  logic [31:0] timer;

  logic all_gt_locked, all_rx_aligned, all_tx_done, all_rx_done;
  logic any_tx_fail, any_rx_failed, cores_idle, cores_busy;

  assign all_gt_locked  = &core_gt_locked;
  assign all_rx_aligned = &core_rx_aligned;
  assign all_tx_done    = &core_tx_done;
  assign all_rx_done    = &core_rx_done;
  assign any_tx_fail    = |core_tx_fail;
  assign any_rx_failed  = |core_rx_failed;
  assign cores_idle     = ~(|core_tx_busy) & ~(|core_rx_busy);
  assign cores_busy     = (&core_tx_busy) & (&core_rx_busy);

  logic in_check_window;
  logic in_timed_state;
  assign in_check_window = (state >= ST_PACKET_SEND) && (state <= ST_BUSY_WAIT);
  assign in_timed_state  = (state >= ST_GT_LOCK_WAIT) && (state <= ST_BUSY_WAIT);

  logic   advance;
  state_t adv_state;

  // Normal forward condition and destination for the current state.
  always_comb begin
    advance   = 1'b0;
    adv_state = state;
    case (state)
      ST_RESET_HOLD:     begin advance = (timer == HOLD_LAST); adv_state = ST_GT_LOCK_WAIT;   end
      ST_GT_LOCK_WAIT:   begin advance = all_gt_locked;        adv_state = ST_RX_ALIGN_WAIT;  end
      ST_RX_ALIGN_WAIT:  begin advance = all_rx_aligned;       adv_state = ST_PACKET_SEND;    end
      ST_PACKET_SEND:    begin advance = all_tx_done;          adv_state = ST_PACKET_RECEIVE; end
      ST_PACKET_RECEIVE: begin advance = all_rx_done;          adv_state = ST_IDLE_WAIT;      end
      ST_IDLE_WAIT: begin
        advance   = cores_idle;
        adv_state = (round_idx == LAST_ROUND) ? ST_DONE : ST_RESTART;
      end
      ST_RESTART:        begin advance = 1'b1;                 adv_state = ST_BUSY_WAIT;      end
      ST_BUSY_WAIT:      begin advance = cores_busy;           adv_state = ST_PACKET_SEND;    end
      default:           begin advance = 1'b0;                 adv_state = state;             end
    endcase
  end

  logic       go;
  state_t     next_state;
  logic [2:0] next_code;

  // Failure checks outrank the forward move; the forward move outranks timeout.
  always_comb begin
    go         = 1'b0;
    next_state = state;
    next_code  = 3'd0;
    if (in_check_window && any_tx_fail) begin
      go = 1'b1; next_state = ST_FAIL; next_code = 3'd1;
    end else if (in_check_window && any_rx_failed) begin
      go = 1'b1; next_state = ST_FAIL; next_code = 3'd2;
    end else if (in_check_window && !all_rx_aligned) begin
      go = 1'b1; next_state = ST_FAIL; next_code = 3'd4;
    end else if (advance) begin
      go = 1'b1; next_state = adv_state;
    end else if (in_timed_state && (timer == TIMEOUT_LAST)) begin
      go = 1'b1; next_state = ST_FAIL; next_code = 3'd3;
    end
  end

  // Sequencer state, dwell timer and all registered status outputs.
  always_ff @(posedge init_clk) begin
    if (clk_reset) begin
      state         <= ST_RESET_HOLD;
      timer         <= '0;
      sys_reset     <= 1'b1;
      tx_rx_restart <= 1'b0;
      pm_tick       <= 1'b0;
      round_idx     <= 8'd0;
      test_pass     <= 1'b0;
      test_fail     <= 1'b0;
      fail_code     <= 3'd0;
      fail_state    <= 4'd0;
    end else begin
      tx_rx_restart <= go && (next_state == ST_RESTART);
      pm_tick       <= go && (state == ST_PACKET_RECEIVE) && (next_state == ST_IDLE_WAIT);
      if (go) begin
        state <= next_state;
        timer <= '0;
        if (next_state == ST_GT_LOCK_WAIT) sys_reset <= 1'b0;
        if (next_state == ST_DONE) test_pass <= 1'b1;
        if (next_state == ST_FAIL) begin
          test_fail  <= 1'b1;
          fail_code  <= next_code;
          fail_state <= state;
        end
        if ((state == ST_BUSY_WAIT) && (next_state == ST_PACKET_SEND) && (round_idx != LAST_ROUND))
          round_idx <= round_idx + 8'd1;
      end else if (timer != '1) begin
        timer <= timer + 32'd1;
      end
    end
  end

  assign state_out = state;

`ifdef INTERLAKEN_SEQ_EVENT_EN
  logic [3:0] ev_code_next;

  // Event identifier for the transition being taken this cycle.
  always_comb begin
    ev_code_next = 4'd0;
    case (next_state)
      ST_PACKET_SEND: ev_code_next = (state == ST_BUSY_WAIT) ? 4'd8 : 4'd3;
      ST_DONE:        ev_code_next = 4'd9;
      ST_FAIL:        ev_code_next = 4'd10;
      default:        ev_code_next = next_state;
    endcase
  end

  // One strobe per state transition, carrying its identifier.
  always_ff @(posedge init_clk) begin
    if (clk_reset) begin
      event_valid <= 1'b0;
      event_code  <= 4'd0;
    end else begin
      event_valid <= go;
      event_code  <= go ? ev_code_next : 4'd0;
    end
  end
`else
  assign event_valid = 1'b0;
  assign event_code  = 4'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_interlaken_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_interlaken_test_sequencer
// Description : Self-checking bench for interlaken_test_sequencer. DUT0 runs
//               directed and randomized core handshakes against a reference
//               model. DUT1 (short timeout) covers the timeout boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interlaken_test_sequencer;

  localparam int P_ROUNDS = 2;
  localparam int P_HOLD   = 4;
  localparam int P_TO0    = 200;
  localparam int P_TO1    = 16;

  logic init_clk = 1'b0;
  always #5 init_clk = ~init_clk;

  // DUT0 ports
  logic       rst0;
  logic [1:0] gl0, ra0, td0, tb0, tf0, rd0, rb0, rf0;
  logic       sr0, rs0, pm0, tp0, tfl0, ev0;
  logic [3:0] st0, fs0, ec0;
  logic [7:0] ri0;
  logic [2:0] fc0;

  // DUT1 ports
  logic       rst1;
  logic [1:0] gl1, ra1, td1, tb1, tf1, rd1, rb1, rf1;
  logic       sr1, rs1, pm1, tp1, tfl1, ev1;
  logic [3:0] st1, fs1, ec1;
  logic [7:0] ri1;
  logic [2:0] fc1;

  interlaken_test_sequencer #(.NUM_CORES(2), .NUM_ROUNDS(P_ROUNDS),
    .RESET_HOLD_CYCLES(P_HOLD), .TIMEOUT_CYCLES(P_TO0)) dut0 (
    .init_clk(init_clk), .clk_reset(rst0),
    .core_gt_locked(gl0), .core_rx_aligned(ra0), .core_tx_done(td0),
    .core_tx_busy(tb0), .core_tx_fail(tf0), .core_rx_done(rd0),
    .core_rx_busy(rb0), .core_rx_failed(rf0),
    .sys_reset(sr0), .tx_rx_restart(rs0), .pm_tick(pm0), .state_out(st0),
    .round_idx(ri0), .test_pass(tp0), .test_fail(tfl0), .fail_code(fc0),
    .fail_state(fs0), .event_valid(ev0), .event_code(ec0));

  interlaken_test_sequencer #(.NUM_CORES(2), .NUM_ROUNDS(P_ROUNDS),
    .RESET_HOLD_CYCLES(P_HOLD), .TIMEOUT_CYCLES(P_TO1)) dut1 (
    .init_clk(init_clk), .clk_reset(rst1),
    .core_gt_locked(gl1), .core_rx_aligned(ra1), .core_tx_done(td1),
    .core_tx_busy(tb1), .core_tx_fail(tf1), .core_rx_done(rd1),
    .core_rx_busy(rb1), .core_rx_failed(rf1),
    .sys_reset(sr1), .tx_rx_restart(rs1), .pm_tick(pm1), .state_out(st1),
    .round_idx(ri1), .test_pass(tp1), .test_fail(tfl1), .fail_code(fc1),
    .fail_state(fs1), .event_valid(ev1), .event_code(ec1));

  int errors = 0;
  int checks = 0;

  // Reference model of DUT0, advanced once per clock edge.
  int m_state, m_timer, m_round, m_code, m_fstate, m_evc;
  bit m_pass, m_fail, m_sys, m_rst_p, m_tick, m_evv;

  // Observation logs from DUT0.
  int q_st[$];
  int q_ev[$];
  int prev_st;
  int cnt_rs, cnt_pm;
  int exp_st [11] = '{1, 2, 3, 4, 5, 6, 7, 3, 4, 5, 8};
  int exp_ev [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 4, 5, 9};
  int stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit adv;
    int dest;
    int code;
    m_rst_p = 1'b0; m_tick = 1'b0; m_evv = 1'b0;
    if (rst0) begin
      m_state = 0; m_timer = 0; m_round = 0; m_pass = 0; m_fail = 0;
      m_code = 0; m_fstate = 0; m_sys = 1;
      return;
    end
    adv = 1'b0; dest = m_state; code = 0;
    case (m_state)
      0: begin adv = (m_timer == P_HOLD - 1); dest = 1; end
      1: begin adv = (gl0 == 2'b11); dest = 2; end
      2: begin adv = (ra0 == 2'b11); dest = 3; end
      3: begin adv = (td0 == 2'b11); dest = 4; end
      4: begin adv = (rd0 == 2'b11); dest = 5; end
      5: begin adv = ((tb0 | rb0) == 2'b00); dest = (m_round == P_ROUNDS - 1) ? 8 : 6; end
      6: begin adv = 1'b1; dest = 7; end
      7: begin adv = (tb0 == 2'b11) && (rb0 == 2'b11); dest = 3; end
      default: adv = 1'b0;
    endcase
    if (m_state >= 3 && m_state <= 7) begin
      if (tf0 != 2'b00)      code = 1;
      else if (rf0 != 2'b00) code = 2;
      else if (ra0 != 2'b11) code = 4;
    end
    if (code == 0 && !adv && m_state >= 1 && m_state <= 7 && m_timer == P_TO0 - 1) code = 3;
    if (code != 0) begin adv = 1'b1; dest = 9; end
    if (adv) begin
      m_evv = 1'b1;
      if (dest == 9)                         m_evc = 10;
      else if (dest == 8)                    m_evc = 9;
      else if (dest == 3 && m_state == 7)    m_evc = 8;
      else                                   m_evc = dest;
      if (dest == 9) begin m_fail = 1; m_code = code; m_fstate = m_state; end
      if (dest == 8) m_pass = 1;
      if (dest == 1) m_sys = 0;
      if (dest == 6) m_rst_p = 1;
      if (m_state == 4 && dest == 5) m_tick = 1;
      if (m_state == 7 && dest == 3 && m_round < P_ROUNDS - 1) m_round++;
      m_state = dest;
      m_timer = 0;
    end else begin
      m_timer++;
    end
  endtask

  task automatic check0();
    chk("state", st0, m_state);
    chk("sys_reset", sr0, m_sys);
    chk("tx_rx_restart", rs0, m_rst_p);
    chk("pm_tick", pm0, m_tick);
    chk("round_idx", ri0, m_round);
    chk("test_pass", tp0, m_pass);
    chk("test_fail", tfl0, m_fail);
    chk("fail_code", fc0, m_code);
    chk("fail_state", fs0, m_fstate);
`ifdef INTERLAKEN_SEQ_EVENT_EN
    chk("event_valid", ev0, m_evv);
    if (m_evv) chk("event_code", ec0, m_evc);
`else
    chk("event_valid_tied", ev0, 0);
    chk("event_code_tied", ec0, 0);
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later.
  task automatic cyc();
    @(posedge init_clk);
    model_edge();
    #1;
    check0();
    cnt_rs += int'(rs0);
    cnt_pm += int'(pm0);
    if (int'(st0) != prev_st) q_st.push_back(int'(st0));
    prev_st = int'(st0);
    if (ev0) q_ev.push_back(int'(ec0));
    @(negedge init_clk);
  endtask

  function automatic logic [1:0] maybe_all(input bit noisy);
    if (noisy && $urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
    return 2'b11;
  endfunction

  function automatic logic [1:0] maybe_none(input bit noisy);
    if (noisy && $urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
    return 2'b00;
  endfunction

  // Model core behaviour for DUT0, following the expected sequencer state.
  task automatic respond(input bit noisy);
    gl0 = 2'b11; ra0 = 2'b11; td0 = 2'b00; tb0 = 2'b11; rb0 = 2'b11;
    rd0 = 2'b00; tf0 = 2'b00; rf0 = 2'b00;
    case (m_state)
      0: begin gl0 = 2'b00; ra0 = 2'b00; tb0 = 2'b00; rb0 = 2'b00; end
      1: begin gl0 = maybe_all(noisy); ra0 = 2'b00; end
      2: ra0 = maybe_all(noisy);
      3: td0 = maybe_all(noisy);
      4: begin td0 = 2'b11; rd0 = maybe_all(noisy); end
      5: begin td0 = 2'b11; rd0 = 2'b11; tb0 = maybe_none(noisy); rb0 = maybe_none(noisy); end
      6: begin tb0 = 2'b00; rb0 = 2'b00; end
      7: begin tb0 = maybe_all(noisy); rb0 = maybe_all(noisy); end
      default: begin
        gl0 = 2'($urandom); ra0 = 2'($urandom); td0 = 2'($urandom); tb0 = 2'($urandom);
        rb0 = 2'($urandom); rd0 = 2'($urandom); tf0 = 2'($urandom); rf0 = 2'($urandom);
      end
    endcase
    if (noisy && m_state < 8) begin
      if ($urandom_range(0, 96) == 0) tf0 = 2'($urandom);
      if ($urandom_range(0, 96) == 0) rf0 = 2'($urandom);
      if ($urandom_range(0, 88) == 0) ra0 = 2'($urandom);
    end
  endtask

  task automatic run_to(input int target, input int budget);
    int left;
    left = budget;
    while (m_state != target && left > 0) begin
      respond(1'b0);
      cyc();
      left--;
    end
    if (m_state != target) begin
      checks++;
      errors++;
      $error("FAIL reach_state: observed %0d expected %0d (cycle budget spent)", m_state, target);
    end
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    cyc();
    rst0 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    {gl0, ra0, td0, tb0, tf0, rd0, rb0, rf0} = '0;
    {gl1, ra1, td1, tb1, tf1, rd1, rb1, rf1} = '0;
    m_state = 0; m_timer = 0; m_round = 0; m_code = 0; m_fstate = 0; m_evc = 0;
    m_pass = 0; m_fail = 0; m_sys = 1; m_rst_p = 0; m_tick = 0; m_evv = 0;
    prev_st = 0; cnt_rs = 0; cnt_pm = 0; stall = 0;
    @(negedge init_clk);

    // Reset held for three cycles.
    repeat (3) cyc();
    chk("reset_state", st0, 0);
    chk("reset_sys_reset", sr0, 1);
    chk("reset_round", ri0, 0);
    chk("reset_pass_fail", {tp0, tfl0}, 0);
    chk("reset_fail_info", {fc0, fs0}, 0);
    chk("reset_event", {ev0, ec0}, 0);

    // Nominal two-round run; sys_reset held through 4 cycles after release.
    q_st.delete(); q_ev.delete(); prev_st = 0; cnt_rs = 0; cnt_pm = 0;
    rst0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      respond(1'b0);
      cyc();
      chk("sys_reset_hold", sr0, (k < 4) ? 1 : 0);
    end
    chk("gt_lock_entry", st0, 1);
    run_to(8, 300);
    chk("nominal_pass", tp0, 1);
    chk("nominal_round", ri0, 1);
    chk("nominal_restarts", cnt_rs, 1);
    chk("nominal_pm_ticks", cnt_pm, 2);
    chk("nominal_state_count", q_st.size(), 11);
    for (int i = 0; i < 11 && i < q_st.size(); i++) chk("nominal_state_seq", q_st[i], exp_st[i]);
`ifdef INTERLAKEN_SEQ_EVENT_EN
    chk("nominal_event_count", q_ev.size(), 11);
    for (int i = 0; i < 11 && i < q_ev.size(); i++) chk("nominal_event_seq", q_ev[i], exp_ev[i]);
`endif
    // Terminal DONE ignores inputs.
    repeat (10) begin respond(1'b1); cyc(); end
    chk("done_sticky", st0, 8);

    // Partial readiness: tx_done 01 for 100 cycles, then 11.
    reset0();
    run_to(3, 100);
    for (int k = 0; k < 100; k++) begin
      respond(1'b0);
      td0 = 2'b01;
      cyc();
    end
    chk("partial_hold", st0, 3);
    respond(1'b0);
    td0 = 2'b11;
    cyc();
    chk("partial_release", st0, 4);

    // rx_done together with tx_fail[1] in PACKET_RECEIVE.
    respond(1'b0);
    tf0 = 2'b10;
    cyc();
    chk("simul_state", st0, 9);
    chk("simul_code", fc0, 1);
    chk("simul_fstate", fs0, 4);
    chk("simul_no_tick", pm0, 0);
    repeat (10) begin respond(1'b1); cyc(); end
    chk("fail_sticky", {st0, tfl0}, {4'd9, 1'b1});

    // Alignment loss in BUSY_WAIT.
    reset0();
    run_to(7, 100);
    respond(1'b0);
    ra0 = 2'b10;
    cyc();
    chk("align_code", fc0, 4);
    chk("align_fstate", fs0, 7);
    chk("align_no_pass", tp0, 0);

    // Reset in PACKET_SEND of round 1, then a full rerun.
    reset0();
    run_to(7, 100);
    run_to(3, 100);
    chk("mid_round", ri0, 1);
    rst0 = 1'b1;
    cyc();
    rst0 = 1'b0;
    chk("mid_reset_state", st0, 0);
    chk("mid_reset_sys", sr0, 1);
    chk("mid_reset_round", ri0, 0);
    chk("mid_reset_sticky", {tp0, tfl0, fc0, fs0}, 0);
    run_to(8, 300);
    chk("rerun_pass", tp0, 1);

    // Timeout boundary on DUT1: no lock, FAIL 16 cycles after GT_LOCK_WAIT entry.
    rst1 = 1'b1; gl1 = 2'b00;
    cyc();
    rst1 = 1'b0;
    repeat (4) cyc();
    chk("to_entry", st1, 1);
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k < 16) chk("to_waiting", st1, 1);
    end
    chk("to_state", st1, 9);
    chk("to_code", fc1, 3);
    chk("to_fstate", fs1, 1);
    chk("to_fail", tfl1, 1);

    // Lock arriving on the timeout cycle wins.
    rst1 = 1'b1;
    cyc();
    rst1 = 1'b0;
    repeat (4) cyc();
    for (int k = 1; k <= 15; k++) cyc();
    gl1 = 2'b11;
    cyc();
    chk("to_late_lock_state", st1, 2);
    chk("to_late_lock_nofail", tfl1, 0);

    // Randomized handshakes with occasional faults, stalls and resets.
    reset0();
    for (int n = 0; n < 4000; n++) begin
      if (stall == 0 && $urandom_range(0, 499) == 0) stall = 250;
      respond(1'b1);
      if (stall > 0) begin
        td0 = 2'b00; rd0 = 2'b00; tb0 = 2'b01; rb0 = 2'b01; gl0 = 2'b00;
        tf0 = 2'b00; rf0 = 2'b00; ra0 = 2'b11;
        stall--;
      end
      rst0 = ($urandom_range(0, 399) == 0) || (m_state >= 8 && $urandom_range(0, 19) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/interlaken_test_sequencer.md
# interlaken_test_sequencer

- Parametrised, multi-core, multi-round test sequencer for the Interlaken loopback test top.
- Aggregates status from NUM_CORES example-design cores.
- Drives their shared system reset, packet-restart and performance-monitor tick.
- Runs NUM_ROUNDS generate/check rounds with per-state timeouts, failure capture and a debug event stream.

## Interface
- NUM_CORES, 2: number of core status vectors aggregated (1..16).
- NUM_ROUNDS, 2: packet rounds per test (1..255).
- RESET_HOLD_CYCLES, 4: cycles sys_reset stays high after clk_reset falls (>=1).
- TIMEOUT_CYCLES, 1048576: max cycles in any waiting state (2..2^24).
- Clock and reset: one clock; reset is synchronous and active-high.
  - init_clk  in  1  sole clock.
  - clk_reset  in  1  synchronous, active-high reset.
- Core status inputs, bit i = core i, sampled on init_clk:
  - core_gt_locked  in  NUM_CORES
  - core_rx_aligned  in  NUM_CORES
  - core_tx_done  in  NUM_CORES
  - core_tx_busy  in  NUM_CORES
  - core_tx_fail  in  NUM_CORES
  - core_rx_done  in  NUM_CORES
  - core_rx_busy  in  NUM_CORES
  - core_rx_failed  in  NUM_CORES
- Outputs:
  - sys_reset  out  1  reset to all cores.
  - tx_rx_restart  out  1  one-cycle packet-restart pulse.
  - pm_tick  out  1  one-cycle pulse at each round completion.
  - state_out  out  4  current state encoding.
  - round_idx  out  8  current round, 0-based.
  - test_pass  out  1  sticky.
  - test_fail  out  1  sticky.
  - fail_code  out  3  cause of failure.
  - fail_state  out  4  state in which the failure was detected.
  - event_valid  out  1  one-cycle event strobe.
  - event_code  out  4  event identifier.

## Operation
- Aggregates, all over NUM_CORES:
  - ALL_x = AND of a status vector.
  - ANY_x = OR of a status vector.
  - IDLE = no tx_busy and no rx_busy bit set.
  - BUSY = ALL_tx_busy & ALL_rx_busy.
- States and transitions:
  - RESET_HOLD(0): sys_reset=1. After RESET_HOLD_CYCLES cycles, go to GT_LOCK_WAIT; sys_reset=0 from that entry.
  - GT_LOCK_WAIT(1): when ALL_gt_locked, go to RX_ALIGN_WAIT.
  - RX_ALIGN_WAIT(2): when ALL_rx_aligned, go to PACKET_SEND. Round 0 is free-running; no restart is issued.
  - PACKET_SEND(3): when ALL_tx_done, go to PACKET_RECEIVE.
  - PACKET_RECEIVE(4): when ALL_rx_done, go to IDLE_WAIT; pm_tick=1 for that one cycle.
  - IDLE_WAIT(5): when IDLE, go to DONE if round_idx==NUM_ROUNDS-1, else to RESTART.
  - RESTART(6): lasts exactly one cycle with tx_rx_restart=1, then BUSY_WAIT.
  - BUSY_WAIT(7): when BUSY, go to PACKET_SEND and increment round_idx.
  - DONE(8): terminal; test_pass=1.
  - FAIL(9): terminal; test_fail=1. fail_code and fail_state are latched on entry.
- Failure checks run in states 3–7 and take priority over the normal transition in the same cycle. Priority when several fire together:
  - ANY_tx_fail: code 1.
  - ANY_rx_failed: code 2.
  - !ALL_rx_aligned (alignment loss): code 4.
  - Timeout: code 3.
- Timeout:
  - A counter clears on every state entry and increments each cycle.
  - In states 1–7, if the advance condition is false when the counter equals TIMEOUT_CYCLES-1, go to FAIL.
  - The advance condition wins on that same cycle.
  - The same counter times RESET_HOLD.
- Events: one event per state transition, code = destination.
  - 1 reset released, 2 GT locked, 3 aligned, 4 all sent, 5 all received.
  - 6 idle (to RESTART), 7 restart issued (to BUSY_WAIT), 8 busy (to PACKET_SEND).
  - 9 pass (to DONE), 10 fail (to FAIL).

## Timing
- All outputs are registered. A transition, its event strobe and its pulse outputs appear on the edge after the enabling inputs are sampled.
- Reset values (clk_reset=1):
  - state_out=0, sys_reset=1.
  - tx_rx_restart=0, pm_tick=0, round_idx=0.
  - test_pass=0, test_fail=0, fail_code=0, fail_state=0.
  - event_valid=0, event_code=0.
- sys_reset:
  - High while clk_reset=1 and for RESET_HOLD_CYCLES cycles after clk_reset falls.
  - Falls on the same edge that state_out becomes 1.
- Reset mid-operation: any state returns to RESET_HOLD on the next edge; all sticky status is cleared.
- round_idx saturates at NUM_ROUNDS-1. With NUM_ROUNDS=1, RESTART is never entered.
- tx_rx_restart pulses and pm_tick pulses are each exactly one cycle wide, never back-to-back.
- DONE and FAIL ignore all inputs until clk_reset.

## Configuration
- INTERLAKEN_SEQ_EVENT_EN:
  - Defined: event_valid/event_code are driven as above.
  - Undefined: both outputs are tied to 0 and the event logic is not synthesised. This is the required setting for hardware builds.
  - State, failure and pass behaviour are identical either way.

## Test plan
- Nominal, NUM_CORES=2, NUM_ROUNDS=2, RESET_HOLD_CYCLES=4:
  - Stimulus: clk_reset for 3 cycles, then a model core handshake.
  - Required: sys_reset is high through 4 cycles after release.
  - Required event sequence: 1,2,3,4,5,6,7,8,4,5,9.
  - Required: exactly one tx_rx_restart pulse, two pm_tick pulses, test_pass=1, round_idx=1.
- Partial readiness:
  - Stimulus: core_tx_done=2'b01 held for 100 cycles, then 2'b11.
  - Required: state stays 3 until 2'b11, then 4 one cycle later.
- Timeout, TIMEOUT_CYCLES=16:
  - Stimulus: gt_locked never asserted.
  - Required: FAIL is entered exactly 16 cycles after GT_LOCK_WAIT entry; fail_code=3, fail_state=1.
  - Stimulus: ALL_gt_locked rises on cycle 16.
  - Required: go to RX_ALIGN_WAIT, no fail.
- Simultaneous events:
  - Stimulus: in PACKET_RECEIVE, ALL_rx_done and core_tx_fail[1] in the same cycle.
  - Required: FAIL with fail_code=1, fail_state=4, no pm_tick.
- Alignment loss:
  - Stimulus: core_rx_aligned drops to 2'b10 in BUSY_WAIT.
  - Required: fail_code=4, fail_state=7, test_pass stays 0.
- Reset mid-test:
  - Stimulus: clk_reset asserted in PACKET_SEND of round 1.
  - Required: next edge state_out=0, sys_reset=1, round_idx=0, all sticky status cleared.
  - Required: a full rerun passes.
